cellrv32_cpu_cp_fpu_i2f: RTL and testbench
==========================================

Name: cellrv32_cpu_cp_fpu_i2f

Overview:
Single-precision Int-To-Float converter. It is the counterpart stage of the float-to-int converter inside the CELLRV32 FPU coprocessor, and serves FCVT.S.W and FCVT.S.WU. It takes a 32-bit integer from the FPU operand path, normalizes it iteratively, rounds it per rmode_i, and delivers a packed IEEE-754 result plus exception flags to the FPU result/flag merge.

Parameters:
XLEN, 32, data path width; only 32 is supported.

Ports:
clk_i  in  1  global clock, rising edge
rstn_i  in  1  global reset, low-active, synchronous
start_i  in  1  trigger operation; sampled only in S_IDLE
rmode_i  in  3  rounding mode (RISC-V frm encoding)
funct_i  in  1  0=signed source, 1=unsigned source
int_i  in  32  integer operand
result_o  out  32  packed float result {sign, exponent[7:0], mantissa[22:0]}
flags_o  out  5  exception flags, indexed by fp_exc_*_c
done_o  out  1  one-cycle pulse, result_o/flags_o valid

Behaviour:
- Reset: one clock, rstn_i synchronous active-low (sampled on the clk_i rising edge only). Reset forces state S_IDLE and clears result_o, flags_o, done_o and all internal registers. Reset mid-operation aborts the conversion with no done_o pulse.
- States: S_IDLE, S_PREPARE, S_NORMALIZE_BUSY, S_ROUND, S_FINALIZE.
- S_IDLE: on start_i=1, latch int_i, funct_i and rmode_i, then go to S_PREPARE. start_i in any other state is ignored.
- S_PREPARE: sign = ~funct & int[31]. mag = sign ? (0 - int) : int, 32-bit unsigned, so 0x80000000 stays 0x80000000. exp = 158 (127+31). Clear sticky.
  - mag==0: result = +0, go to S_FINALIZE.
  - Otherwise go to S_NORMALIZE_BUSY.
- S_NORMALIZE_BUSY:
  - mag[31]==1: go to S_ROUND.
  - Otherwise: mag <= mag<<1, exp <= exp-1.
  - Occupies lz+1 cycles, where lz is the leading-zero count (0..31).
- S_ROUND:
  - Fields: frac = mag[30:8], G = mag[7], R = mag[6], S = |mag[5:0], inexact = G|R|S.
  - RNE (000): increment iff G & (R|S|frac[0]).
  - RTZ (001): never increment.
  - RDN (010): increment iff inexact & sign.
  - RUP (011): increment iff inexact & ~sign.
  - RMM (100): increment iff G.
  - Other codes: behave as RTZ.
  - Increment is 24-bit on {1,frac}. A carry-out sets frac=0 and exp=exp+1. Maximum exponent is 159 (2^32), so no overflow to inf is possible.
  - Latch NX = inexact.
- S_FINALIZE: result_o <= {sign, exp, frac}. flags_o: nx = latched inexact; nv/dz/of/uf = 0. done_o <= 1 for exactly one cycle. Return to S_IDLE.
- Latency, counted in edges from the start-sampling edge to the edge raising done_o:
  - Zero input: 2.
  - Non-zero input: lz+4, which is 4..35.
- result_o/flags_o hold their value until the next S_FINALIZE or reset. A new start_i is accepted in the cycle done_o is high, because the state is already S_IDLE.

Optional Feature:
CELLRV32_FPU_I2F_LZC_EN
- Defined: S_NORMALIZE_BUSY is a single cycle. A combinational leading-zero counter performs mag <= mag<<lz and exp <= 158-lz. Non-zero latency is fixed at 4 edges.
- Undefined: iterative one-bit-per-cycle shift as above, with minimal area.
- Results and flags are bit-identical in both builds.

Test Plan:
- Signed int_i=0x00000001, RNE -> result 0x3F800000, flags 0, done_o 35 edges after start (4 with LZC).
- Signed int_i=0xFFFFFFFF, RNE -> 0xBF800000, no NX. Unsigned int_i=0xFFFFFFFF, RNE -> 0x4F800000 with NX=1 (exercises exponent carry).
- int_i=0x01000001 across modes:
  - RNE -> 0x4B800000, NX=1 (tie to even).
  - RUP -> 0x4B800001.
  - RTZ -> 0x4B800000.
  - Signed 0xFEFFFFFF under RDN -> 0xCB800001.
- Signed int_i=0x80000000 -> 0xCF000000, NX=0. Unsigned int_i=0x80000000 -> 0x4F000000.
- int_i=0 -> 0x00000000, flags 0, done_o 2 edges after start. start_i held high during a busy conversion -> exactly one done_o pulse.
- rstn_i=0 for one cycle during S_NORMALIZE_BUSY -> no done_o; result_o=0, flags_o=0; a subsequent start converts correctly.

Source files
------------

// File: rtl/cellrv32_cpu_cp_fpu_i2f.sv
// Int-to-float converter (FCVT.S.W / FCVT.S.WU): normalize, round, pack.
// Optional macro CELLRV32_FPU_I2F_LZC_EN: single-cycle leading-zero normalization.
module cellrv32_cpu_cp_fpu_i2f #(
  parameter int XLEN = 32
) (
  input  logic            clk_i,
  input  logic            rstn_i,
  input  logic            start_i,
  input  logic [2:0]      rmode_i,
  input  logic            funct_i,
  input  logic [XLEN-1:0] int_i,
  output logic [31:0]     result_o,
  output logic [4:0]      flags_o,
  output logic            done_o
);

  localparam int unsigned EXP_W  = 8;
  localparam int unsigned FRAC_W = 23;
  localparam int unsigned FLAG_W = 5;
  localparam logic [EXP_W-1:0] EXP_TOP = EXP_W'(158);

  localparam logic [2:0] RM_RNE = 3'b000;
  localparam logic [2:0] RM_RTZ = 3'b001;
  localparam logic [2:0] RM_RDN = 3'b010;
  localparam logic [2:0] RM_RUP = 3'b011;
  localparam logic [2:0] RM_RMM = 3'b100;

  localparam int unsigned FP_EXC_NX_C = 0;

  typedef enum logic [2:0] {
    S_IDLE,
    S_PREPARE,
    S_NORMALIZE_BUSY,
    S_ROUND,
    S_FINALIZE
  } state_t;

  state_t              state_q, state_d;
  logic [XLEN-1:0]     mag_q, mag_d;
  logic [EXP_W-1:0]    exp_q, exp_d;
  logic [FRAC_W-1:0]   frac_q, frac_d;
  logic                sign_q, sign_d;
  logic                funct_q, funct_d;
  logic [2:0]          rmode_q, rmode_d;
  logic                nx_q, nx_d;
  logic [31:0]         result_q, result_d;
  logic [FLAG_W-1:0]   flags_q, flags_d;
  logic                done_q, done_d;

  // Rounding on the normalized magnitude: frac = mag[30:8], G/R/S below it
  logic        rnd_g, rnd_r, rnd_s, rnd_inexact, rnd_inc;
  logic [24:0] rnd_sum;

  always_comb begin
    rnd_g       = mag_q[7];
    rnd_r       = mag_q[6];
    rnd_s       = |mag_q[5:0];
    rnd_inexact = rnd_g | rnd_r | rnd_s;
    rnd_inc     = 1'b0;
    case (rmode_q)
      RM_RNE:  rnd_inc = rnd_g & (rnd_r | rnd_s | mag_q[8]);
      RM_RTZ:  rnd_inc = 1'b0;
      RM_RDN:  rnd_inc = rnd_inexact & sign_q;
      RM_RUP:  rnd_inc = rnd_inexact & ~sign_q;
      RM_RMM:  rnd_inc = rnd_g;
      default: rnd_inc = 1'b0;
    endcase
    rnd_sum = 25'({1'b1, mag_q[30:8]}) + 25'(rnd_inc);
  end

`ifdef CELLRV32_FPU_I2F_LZC_EN
  logic [4:0] lz_c;

  // Leading-zero count; only meaningful for a non-zero magnitude
  always_comb begin
    lz_c = 5'd0;
    for (int i = 0; i < 32; i++) begin
      if (mag_q[i]) lz_c = 5'(31 - i);
    end
  end
`endif

  always_comb begin
    state_d  = state_q;
    mag_d    = mag_q;
    exp_d    = exp_q;
    frac_d   = frac_q;
    sign_d   = sign_q;
    funct_d  = funct_q;
    rmode_d  = rmode_q;
    nx_d     = nx_q;
    result_d = result_q;
    flags_d  = flags_q;
    done_d   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          mag_d   = int_i;
          funct_d = funct_i;
          rmode_d = rmode_i;
          state_d = S_PREPARE;
        end
      end

      S_PREPARE: begin
        sign_d = ~funct_q & mag_q[31];
        mag_d  = (~funct_q & mag_q[31]) ? (XLEN'(0) - mag_q) : mag_q;
        exp_d  = EXP_TOP;
        nx_d   = 1'b0;
        if (mag_q == '0) begin
          sign_d  = 1'b0;
          exp_d   = '0;
          frac_d  = '0;
          state_d = S_FINALIZE;
        end else begin
          state_d = S_NORMALIZE_BUSY;
        end
      end

      S_NORMALIZE_BUSY: begin
`ifdef CELLRV32_FPU_I2F_LZC_EN
        mag_d   = mag_q << lz_c;
        exp_d   = EXP_TOP - EXP_W'(lz_c);
        state_d = S_ROUND;
`else
        if (mag_q[31]) begin
          state_d = S_ROUND;
        end else begin
          mag_d = mag_q << 1;
          exp_d = exp_q - EXP_W'(1);
        end
`endif
      end

      S_ROUND: begin
        // A carry out of the 24-bit significand leaves frac at zero and bumps exp
        frac_d  = rnd_sum[22:0];
        exp_d   = exp_q + EXP_W'(rnd_sum[24]);
        nx_d    = rnd_inexact;
        state_d = S_FINALIZE;
      end

      S_FINALIZE: begin
        result_d = {sign_q, exp_q, frac_q};
        flags_d  = '0;
        flags_d[FP_EXC_NX_C] = nx_q;
        done_d   = 1'b1;
        state_d  = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      state_q  <= S_IDLE;
      mag_q    <= '0;
      exp_q    <= '0;
      frac_q   <= '0;
      sign_q   <= 1'b0;
      funct_q  <= 1'b0;
      rmode_q  <= '0;
      nx_q     <= 1'b0;
      result_q <= '0;
      flags_q  <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      mag_q    <= mag_d;
      exp_q    <= exp_d;
      frac_q   <= frac_d;
      sign_q   <= sign_d;
      funct_q  <= funct_d;
      rmode_q  <= rmode_d;
      nx_q     <= nx_d;
      result_q <= result_d;
      flags_q  <= flags_d;
      done_q   <= done_d;
    end
  end

  assign result_o = result_q;
  assign flags_o  = flags_q;
  assign done_o   = done_q;

endmodule

// File: tb/tb_cellrv32_cpu_cp_fpu_i2f.sv
// Self-checking bench for cellrv32_cpu_cp_fpu_i2f: directed cases plus random
// operands compared against an arithmetic int-to-float reference model.
module tb_cellrv32_cpu_cp_fpu_i2f;

  logic        clk_i = 1'b0;
  logic        rstn_i;
  logic        start_i;
  logic [2:0]  rmode_i;
  logic        funct_i;
  logic [31:0] int_i;
  logic [31:0] result_o;
  logic [4:0]  flags_o;
  logic        done_o;

  int checks = 0;
  int errors = 0;

  cellrv32_cpu_cp_fpu_i2f #(.XLEN(32)) dut (
    .clk_i    (clk_i),
    .rstn_i   (rstn_i),
    .start_i  (start_i),
    .rmode_i  (rmode_i),
    .funct_i  (funct_i),
    .int_i    (int_i),
    .result_o (result_o),
    .flags_o  (flags_o),
    .done_o   (done_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Reference: exact integer value rounded to 24 significant bits
  function automatic void model(input logic [31:0] x, input logic f, input logic [2:0] rm,
                                output logic [31:0] res, output logic nx, output int lat);
    logic            sgn;
    longint unsigned m, keep, rem, half;
    int              e, sh;
    logic            inc;
    sgn = !f && x[31];
    m   = sgn ? (64'h1_0000_0000 - {32'b0, x}) : {32'b0, x};
    if (m == 0) begin
      res = 32'h0; nx = 1'b0; lat = 2;
      return;
    end
    e = 31;
    while ((m >> e) == 0) e--;
`ifdef CELLRV32_FPU_I2F_LZC_EN
    lat = 4;
`else
    lat = (31 - e) + 4;
`endif
    if (e <= 23) begin
      keep = m << (23 - e);
      rem  = 0;
      half = 1;
    end else begin
      sh   = e - 23;
      keep = m >> sh;
      rem  = m - (keep << sh);
      half = 64'd1 << (sh - 1);
    end
    case (rm)
      3'd0:    inc = (rem > half) || (rem == half && rem != 0 && keep[0]);
      3'd2:    inc = (rem != 0) && sgn;
      3'd3:    inc = (rem != 0) && !sgn;
      3'd4:    inc = (rem != 0) && (rem >= half);
      default: inc = 1'b0;
    endcase
    keep = keep + 64'(inc);
    if (keep == (64'd1 << 24)) begin
      keep = 64'd1 << 23;
      e++;
    end
    nx  = (rem != 0);
    res = {sgn, 8'(e + 127), keep[22:0]};
  endfunction

  // Launch one conversion and return edges until done_o (0 on timeout)
  task automatic run(input logic [31:0] x, input logic f, input logic [2:0] rm, output int lat);
    @(posedge clk_i); #1;
    start_i = 1'b1; int_i = x; funct_i = f; rmode_i = rm;
    @(posedge clk_i); #1;
    start_i = 1'b0; int_i = $urandom;
    lat = 0;
    for (int n = 1; n <= 60; n++) begin
      @(posedge clk_i); #1;
      if (done_o) begin
        lat = n;
        break;
      end
    end
  endtask

  task automatic conv(input string tag, input logic [31:0] x, input logic f, input logic [2:0] rm);
    logic [31:0] eres;
    logic        enx;
    int          elat, lat;
    model(x, f, rm, eres, enx, elat);
    run(x, f, rm, lat);
    chk({tag, "_lat"}, 32'(lat), 32'(elat));
    chk({tag, "_res"}, result_o, eres);
    chk({tag, "_flg"}, 32'(flags_o), {31'b0, enx});
    @(posedge clk_i); #1;
    chk({tag, "_pulse"}, 32'(done_o), 32'd0);
    chk({tag, "_hold"}, result_o, eres);
  endtask

  initial begin
    int          pulses;
    logic [31:0] x;
    rstn_i = 1'b0; start_i = 1'b0; rmode_i = '0; funct_i = 1'b0; int_i = '0;
    repeat (2) @(posedge clk_i);
    #1;
    chk("rst_res", result_o, 32'h0);
    chk("rst_flg", 32'(flags_o), 32'h0);
    chk("rst_done", 32'(done_o), 32'h0);
    rstn_i = 1'b1;

    // Directed cases with hand-derived constants
    conv("one", 32'h0000_0001, 1'b0, 3'd0);
    chk("one_c", result_o, 32'h3F80_0000);
    conv("m1", 32'hFFFF_FFFF, 1'b0, 3'd0);
    chk("m1_c", result_o, 32'hBF80_0000);
    conv("umax", 32'hFFFF_FFFF, 1'b1, 3'd0);
    chk("umax_c", {result_o[31:1], flags_o[0]}, {31'h27C0_0000, 1'b1});
    conv("tie_rne", 32'h0100_0001, 1'b0, 3'd0);
    chk("tie_rne_c", {result_o[31:1], flags_o[0]}, {31'h25C0_0000, 1'b1});
    conv("tie_rup", 32'h0100_0001, 1'b0, 3'd3);
    chk("tie_rup_c", result_o, 32'h4B80_0001);
    conv("tie_rtz", 32'h0100_0001, 1'b0, 3'd1);
    chk("tie_rtz_c", result_o, 32'h4B80_0000);
    conv("neg_rdn", 32'hFEFF_FFFF, 1'b0, 3'd2);
    chk("neg_rdn_c", result_o, 32'hCB80_0001);
    conv("smin", 32'h8000_0000, 1'b0, 3'd0);
    chk("smin_c", {result_o[31:1], flags_o[0]}, {31'h6780_0000, 1'b0});
    conv("u2_31", 32'h8000_0000, 1'b1, 3'd0);
    chk("u2_31_c", result_o, 32'h4F00_0000);
    conv("zero", 32'h0000_0000, 1'b0, 3'd3);
    chk("zero_c", result_o, 32'h0000_0000);
    conv("rmm", 32'h0100_0001, 1'b1, 3'd4);
    conv("bad_rm", 32'h0100_0003, 1'b0, 3'd6);

    // start_i held high across a busy conversion: only one pulse
    @(posedge clk_i); #1;
    start_i = 1'b1; int_i = 32'h0000_0001; funct_i = 1'b0; rmode_i = 3'd0;
    repeat (3) @(posedge clk_i);
    #1;
    start_i = 1'b0;
    pulses = 0;
    for (int n = 0; n < 50; n++) begin
      @(posedge clk_i); #1;
      if (done_o) pulses++;
    end
    chk("busy_pulses", 32'(pulses), 32'd1);
    chk("busy_res", result_o, 32'h3F80_0000);

    // Make result/flags non-zero, then abort a conversion with reset
    conv("pre_rst", 32'h0100_0001, 1'b0, 3'd0);
    @(posedge clk_i); #1;
    start_i = 1'b1; int_i = 32'h0000_0001; funct_i = 1'b0; rmode_i = 3'd0;
    @(posedge clk_i); #1;
    start_i = 1'b0;
    @(posedge clk_i); #1;
    rstn_i = 1'b0;
    @(posedge clk_i); #1;
    rstn_i = 1'b1;
    chk("abort_res", result_o, 32'h0);
    chk("abort_flg", 32'(flags_o), 32'h0);
    pulses = 0;
    for (int n = 0; n < 45; n++) begin
      @(posedge clk_i); #1;
      if (done_o) pulses++;
    end
    chk("abort_pulses", 32'(pulses), 32'd0);
    conv("post_rst", 32'h0000_0005, 1'b0, 3'd0);
    chk("post_rst_c", result_o, 32'h40A0_0000);

    // Random operands spread over all leading-zero counts and rounding modes
    for (int i = 0; i < 250; i++) begin
      x = $urandom >> $urandom_range(0, 31);
      if ($urandom_range(0, 3) == 0) x = -x;
      conv("rnd", x, 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
